// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and FSM state encoding for the irq_latch4 slice.
//   NUM_REQ     number of request lines
//   CODE_W      width of the binary code presented downstream
//   irq_state_e issue FSM states (ST_IDLE, ST_PRESENT)
//   code_mask   one-hot mask for a code, used to clear the accepted pending bit
package irq_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CODE_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

  function automatic logic [NUM_REQ-1:0] code_mask(input logic [CODE_W-1:0] c);
    return NUM_REQ'(1) << c;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// prio_enc4: combinational 4-input priority encoder, bit 3 highest.
//   pending  in   pending request vector
//   code     out  index of the highest set bit (0 when none set)
//   any      out  at least one bit of pending is set
module prio_enc4
  import irq_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  output logic [CODE_W-1:0]  code,
  output logic               any
);

  always_comb begin
    any  = |pending;
    code = '0;
    if (pending[3]) begin
      code = 2'd3;
    end else if (pending[2]) begin
      code = 2'd2;
    end else if (pending[1]) begin
      code = 2'd1;
    end else begin
      code = 2'd0;
    end
  end

endmodule

// File: rtl/irq_latch4.sv
// irq_latch4: four-line rising-edge interrupt latch with prioritized,
// valid/ready-handshaked code issue and a sticky overflow flag.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   capture and issue enable
//   req[3:0]  in   level request lines, bit 3 highest priority
//   ready     in   downstream accepts the presented code this cycle
//   valid     out  a code is presented
//   code[1:0] out  index of the presented request
//   pending   out  registered pending vector
//   overflow  out  sticky: an edge hit an already-pending bit
module irq_latch4
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic               valid,
  output logic [CODE_W-1:0]  code,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);

  irq_state_e         state_q;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_d;
  logic [CODE_W-1:0]  code_q;
  logic               valid_q;
  logic               overflow_q;

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] set_mask;
  logic [NUM_REQ-1:0] clr_mask;
  logic               accept;
  logic               lost;
  logic [CODE_W-1:0]  enc_code;
  logic               enc_any;

  prio_enc4 u_prio_enc4 (
    .pending (pending_q),
    .code    (enc_code),
    .any     (enc_any)
  );

  always_comb begin
    rise     = req & ~req_q;
    // Edges seen while disabled are dropped; req_q still tracks the line.
    set_mask = en ? rise : '0;
    accept   = (state_q == ST_PRESENT) && ready;
    clr_mask = accept ? code_mask(code_q) : '0;
    // Set is applied after clear, so a same-cycle re-edge keeps the bit.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    lost      = |(set_mask & pending_q & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      if (lost) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          // Selection uses the registered vector, so a capture at edge k
          // is presented at edge k+1 at the earliest.
          if (en && enc_any) begin
            code_q  <= enc_code;
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Code is frozen until accepted, regardless of en or new pending.
          if (ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_latch4.sv
// tb_irq_latch4: directed scenario tasks plus a randomized run checked
// against a behavioural reference model of the latch.
module tb_irq_latch4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       ready;
  logic       valid;
  logic [1:0] code;
  logic [3:0] pending;
  logic       overflow;

  int n_checks;
  int n_fail;

  // Reference model state.
  bit         m_pend[4];
  bit         m_prev[4];
  bit         m_ovf;
  bit         m_valid;
  int         m_code;

  irq_latch4 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock of the behavioural rules, using the inputs present at the edge.
  task automatic model_step();
    bit accept;
    bit nxt[4];
    bit any;
    int top;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
      end
      m_ovf   = 0;
      m_valid = 0;
      m_code  = 0;
      return;
    end
    accept = m_valid && ready;
    for (int i = 0; i < 4; i++) begin
      bit captured;
      bit cleared;
      captured = en && req[i] && !m_prev[i];
      cleared  = accept && (m_code == i);
      if (captured && m_pend[i] && !cleared) m_ovf = 1;
      nxt[i] = captured ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
    end
    if (!m_valid) begin
      any = 0;
      top = 0;
      for (int i = 3; i >= 0; i--) begin
        if (m_pend[i] && !any) begin
          any = 1;
          top = i;
        end
      end
      if (en && any) begin
        m_valid = 1;
        m_code  = top;
      end
    end else if (accept) begin
      m_valid = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = nxt[i];
      m_prev[i] = req[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b1;
    req   = 4'b0000;
    ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({valid, code} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valid_code: got %b_%b want 0_00", valid, code);
    end
    n_checks++;
    if ({pending, overflow} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL reset_pending_ovf: got %b_%b want 0000_0", pending, overflow);
    end
  endtask

  task automatic test_single_event();
    do_reset();
    ready = 1'b1;
    req   = 4'b0100;
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL single_capture: got %b_%b want 0_0100", valid, pending);
    end
    req = 4'b0000;
    cycle();
    n_checks++;
    if ({valid, code} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL single_present: got %b_%b want 1_10", valid, code);
    end
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL single_accept: got %b_%b want 0_0000", valid, pending);
    end
    cycle();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_once: got %b want 0", valid);
    end
  endtask

  task automatic test_priority_hold();
    do_reset();
    req = 4'b1001;
    cycle();
    req = 4'b0000;
    cycle();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({valid, code} !== 3'b1_11) begin
        n_fail++;
        $display("FAIL prio_stall%0d: got %b_%b want 1_11", i, valid, code);
      end
      cycle();
    end
    ready = 1'b1;
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0001) begin
      n_fail++;
      $display("FAIL prio_accept: got %b_%b want 0_0001", valid, pending);
    end
    cycle();
    n_checks++;
    if ({valid, code} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL prio_second: got %b_%b want 1_00", valid, code);
    end
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL prio_drain: got %b_%b want 0_0000", valid, pending);
    end
  endtask

  task automatic test_late_priority();
    do_reset();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    cycle();
    req = 4'b0100;
    cycle();
    n_checks++;
    if ({valid, code, pending} !== 7'b1_01_0110) begin
      n_fail++;
      $display("FAIL late_hold: got %b_%b_%b want 1_01_0110", valid, code, pending);
    end
    req = 4'b0000;
    cycle();
    cycle();
    n_checks++;
    if ({valid, code} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL late_still: got %b_%b want 1_01", valid, code);
    end
    ready = 1'b1;
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL late_accept: got %b_%b want 0_0100", valid, pending);
    end
    cycle();
    n_checks++;
    if ({valid, code} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL late_next: got %b_%b want 1_10", valid, code);
    end
    cycle();
  endtask

  task automatic test_overflow();
    int issued;
    do_reset();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    cycle();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    n_checks++;
    if ({overflow, pending, valid, code} !== 8'b1_0010_1_01) begin
      n_fail++;
      $display("FAIL ovf_set: got %b_%b_%b_%b want 1_0010_1_01",
               overflow, pending, valid, code);
    end
    ready = 1'b1;
    cycle();
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) issued++;
      n_checks++;
      if (overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_sticky%0d: got %b want 1", i, overflow);
      end
      cycle();
    end
    n_checks++;
    if (issued != 0) begin
      n_fail++;
      $display("FAIL ovf_single_issue: got %0d extra issues want 0", issued);
    end
    do_reset();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_reset: got %b want 0", overflow);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    req = 4'b0001;
    cycle();
    req = 4'b0000;
    cycle();
    ready = 1'b1;
    req   = 4'b0001;
    cycle();
    n_checks++;
    if ({valid, pending, overflow} !== 6'b0_0001_0) begin
      n_fail++;
      $display("FAIL setwin_clear: got %b_%b_%b want 0_0001_0", valid, pending, overflow);
    end
    req = 4'b0000;
    cycle();
    n_checks++;
    if ({valid, code} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL setwin_reissue: got %b_%b want 1_00", valid, code);
    end
    cycle();
    n_checks++;
    if ({valid, pending, overflow} !== 6'b0_0000_0) begin
      n_fail++;
      $display("FAIL setwin_drain: got %b_%b_%b want 0_0000_0", valid, pending, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    req = 4'b1000;
    cycle();
    req = 4'b0100;
    cycle();
    ready = 1'b1;
    rst   = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({valid, pending, overflow, code} !== 8'b0_0000_0_00) begin
      n_fail++;
      $display("FAIL rstmid_clear: got %b_%b_%b_%b want 0_0000_0_00",
               valid, pending, overflow, code);
    end
    en  = 1'b0;
    req = 4'b0000;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      req = 4'b1111;
      cycle();
      if (valid || pending != 0) seen++;
      req = 4'b0000;
      cycle();
      if (valid || pending != 0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_en0: got %0d active cycles want 0", seen);
    end
    // A line held high through reset release counts as one edge.
    en  = 1'b1;
    rst = 1'b1;
    req = 4'b0100;
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL held_release: got %b_%b want 0_0100", valid, pending);
    end
    cycle();
    cycle();
    cycle();
    n_checks++;
    if ({valid, pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL held_one_edge: got %b_%b want 0_0000", valid, pending);
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] flip;
    logic [8:0] want;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 2) != 0);
      flip  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req   = req ^ flip;
      cycle();
      want = {m_valid, 2'(m_code), m_pend_vec(), m_ovf};
      n_checks++;
      if ({valid, code, pending, overflow} !== want) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got v%b c%b p%b o%b want v%b c%b p%b o%b", n,
                 valid, code, pending, overflow, want[8], want[7:6], want[5:2], want[0]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    req      = 4'b0000;
    ready    = 1'b0;
    test_reset();
    test_single_event();
    test_priority_hold();
    test_late_priority();
    test_overflow();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
